// File: rtl/cache_line_fill.sv
// Line refill engine: fetches one cache line word by word from memory over a
// req/ack handshake, writes each word into the data array, then the tag entry.
module cache_line_fill #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 8,
  parameter int INDEX_W        = 4
) (
  input  logic                                            CLK,
  input  logic                                            RST_N,
  input  logic                                            fill_start,
  input  logic [ADDR_W-1:0]                               miss_addr,
  output logic                                            busy,
  output logic                                            fill_done,
  output logic                                            mem_req,
  output logic [ADDR_W-1:0]                               mem_addr,
  input  logic                                            mem_ack,
  input  logic [DATA_W-1:0]                               mem_rdata,
  output logic                                            cache_we,
  output logic [INDEX_W-1:0]                              cache_index,
  output logic [$clog2(WORDS_PER_LINE)-1:0]               cache_word,
  output logic [DATA_W-1:0]                               cache_wdata,
  output logic                                            tag_we,
  output logic [ADDR_W-INDEX_W-$clog2(WORDS_PER_LINE)-3:0] tag_wdata
);

  localparam int CNT_W = $clog2(WORDS_PER_LINE);
  localparam int OFF   = CNT_W + 2;
  localparam logic [CNT_W-1:0]  LAST     = {CNT_W{1'b1}};
  localparam logic [ADDR_W-1:0] OFF_MASK = {{(ADDR_W-OFF){1'b1}}, {OFF{1'b0}}};

  typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  line_base;
  logic [DATA_W-1:0]  rdata_p0;
  logic [ADDR_W-1:0]  word_addr;

  assign word_addr = line_base + {{(ADDR_W-OFF){1'b0}}, cnt, 2'b00};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (fill_start) state_nx = REQ;
      REQ:     if (mem_ack)    state_nx = WRITE;
      WRITE:   state_nx = (cnt == LAST) ? DONE : REQ;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Word counter saturates at the last word so the line never wraps.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (state == IDLE && fill_start) begin
      cnt <= '0;
    end else if (state == WRITE && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Datapath registers carry no reset; outputs are gated by state instead.
  always_ff @(posedge CLK) begin
    if (state == IDLE && fill_start) line_base <= miss_addr & OFF_MASK;
    if (state == REQ && mem_ack)     rdata_p0  <= mem_rdata;
  end

  always_comb begin
    busy        = (state != IDLE);
    mem_req     = 1'b0;
    mem_addr    = '0;
    cache_we    = 1'b0;
    cache_index = '0;
    cache_word  = '0;
    cache_wdata = '0;
    tag_we      = 1'b0;
    tag_wdata   = '0;
    fill_done   = 1'b0;
    case (state)
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = word_addr;
      end
      WRITE: begin
        cache_we    = 1'b1;
        cache_index = line_base[OFF +: INDEX_W];
        cache_word  = cnt;
        cache_wdata = rdata_p0;
      end
      DONE: begin
        tag_we      = 1'b1;
        fill_done   = 1'b1;
        cache_index = line_base[OFF +: INDEX_W];
        tag_wdata   = line_base[ADDR_W-1:OFF+INDEX_W];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed bench for cache_line_fill: reset, fills at several memory speeds,
// ignored restarts, mid-fill reset, back-to-back starts and stray acks.
module tb_cache_line_fill;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        CLK;
  logic        RST_N;
  logic        fill_start;
  logic [31:0] miss_addr;
  logic        busy, fill_done, mem_req, mem_ack;
  logic [31:0] mem_addr, mem_rdata;
  logic        cache_we, tag_we;
  logic [3:0]  cache_index;
  logic [2:0]  cache_word;
  logic [31:0] cache_wdata;
  logic [22:0] tag_wdata;

  int vecs;
  int errs;
  int resp_mode;   // 0: ack low, 1: memory model, 2: ack stuck high
  int ack_delay;

  cache_line_fill #(.ADDR_W(32), .DATA_W(32), .WORDS_PER_LINE(8), .INDEX_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .fill_start(fill_start), .miss_addr(miss_addr),
    .busy(busy), .fill_done(fill_done), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .cache_we(cache_we),
    .cache_index(cache_index), .cache_word(cache_word), .cache_wdata(cache_wdata),
    .tag_we(tag_we), .tag_wdata(tag_wdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory responder: data word = address ^ KEY, ack after ack_delay waiting cycles.
  initial begin
    int wc;
    wc = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge CLK); #1;
      if (resp_mode == 2) begin
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; wc = 0;
      end else if (resp_mode == 1 && mem_req) begin
        if (wc >= ack_delay) begin
          mem_ack = 1'b1; mem_rdata = mem_addr ^ KEY; wc = 0;
        end else begin
          mem_ack = 1'b0; wc++;
        end
      end else begin
        mem_ack = 1'b0; wc = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; fill_start = 1'b0; miss_addr = 32'h0;
    resp_mode = 0; ack_delay = 0;
    repeat (3) cyc();
    vecs++;
    if (busy !== 1'b0 || fill_done !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0 ||
        cache_we !== 1'b0 || cache_index !== 4'h0 || cache_word !== 3'h0 ||
        cache_wdata !== 32'h0 || tag_we !== 1'b0 || tag_wdata !== 23'h0) begin
      errs++;
      $display("FAIL reset_outputs: busy=%b done=%b req=%b addr=%h we=%b tag_we=%b, required all 0",
               busy, fill_done, mem_req, mem_addr, cache_we, tag_we);
    end
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      vecs++;
      if (mem_req !== 1'b0 || busy !== 1'b0) begin
        errs++;
        $display("FAIL idle_after_reset: cycle %0d req=%b busy=%b, required 0 0", i, mem_req, busy);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] base;
    int w;
    bit got;
    base = 32'h0000_1220; w = 0; got = 0;
    resp_mode = 1; ack_delay = 0;
    miss_addr = 32'h0000_1234; fill_start = 1'b1;
    cyc();
    fill_start = 1'b0; miss_addr = 32'h0;
    for (int n = 1; n <= 60 && !got; n++) begin
      if (mem_req) begin
        vecs++;
        if (mem_addr !== base + 32'(4*w)) begin
          errs++; $display("FAIL basic_addr: got %h required %h", mem_addr, base + 32'(4*w));
        end
      end
      if (cache_we) begin
        vecs++;
        if (cache_word !== 3'(w) || cache_index !== 4'h1 || cache_wdata !== ((base + 32'(4*w)) ^ KEY)) begin
          errs++; $display("FAIL basic_write: word=%0d idx=%h data=%h required word=%0d idx=1 data=%h",
                           cache_word, cache_index, cache_wdata, w, (base + 32'(4*w)) ^ KEY);
        end
        w++;
      end
      if (fill_done) begin
        got = 1;
        vecs++;
        if (n != 17 || tag_we !== 1'b1 || tag_wdata !== 23'h9 || w != 8) begin
          errs++; $display("FAIL basic_done: cycle=%0d tag_we=%b tag=%h words=%0d required 17 1 00009 8",
                           n, tag_we, tag_wdata, w);
        end
      end else cyc();
    end
    vecs++;
    if (!got) begin errs++; $display("FAIL basic_timeout: fill_done=0 required 1 within 60 cycles"); end
    cyc();
    vecs++;
    if (busy !== 1'b0 || fill_done !== 1'b0) begin
      errs++; $display("FAIL basic_return_idle: busy=%b done=%b required 0 0", busy, fill_done);
    end
  endtask

  task automatic test_slow_memory();
    logic [31:0] base;
    int w;
    bit got;
    base = 32'hABCD_EF60; w = 0; got = 0;
    resp_mode = 1; ack_delay = 3;
    miss_addr = 32'hABCD_EF64; fill_start = 1'b1;
    cyc();
    fill_start = 1'b0; miss_addr = 32'h0;
    for (int n = 1; n <= 100 && !got; n++) begin
      if (mem_req) begin
        vecs++;
        if (mem_addr !== base + 32'(4*w)) begin
          errs++; $display("FAIL slow_addr_stable: got %h required %h", mem_addr, base + 32'(4*w));
        end
      end
      if (cache_we) begin
        vecs++;
        if (cache_word !== 3'(w) || cache_index !== 4'hB || cache_wdata !== ((base + 32'(4*w)) ^ KEY)) begin
          errs++; $display("FAIL slow_write: word=%0d idx=%h data=%h required word=%0d idx=b data=%h",
                           cache_word, cache_index, cache_wdata, w, (base + 32'(4*w)) ^ KEY);
        end
        w++;
      end
      if (fill_done) begin
        got = 1;
        vecs++;
        if (n != 41 || tag_wdata !== 23'h55E6F7 || w != 8) begin
          errs++; $display("FAIL slow_done: cycle=%0d tag=%h words=%0d required 41 55e6f7 8", n, tag_wdata, w);
        end
      end else cyc();
    end
    vecs++;
    if (!got) begin errs++; $display("FAIL slow_timeout: fill_done=0 required 1 within 100 cycles"); end
    ack_delay = 0;
    cyc();
  endtask

  task automatic test_restart_ignored();
    logic [31:0] base;
    int w, extra;
    bit got, inj;
    base = 32'h0000_1220; w = 0; got = 0; inj = 0; extra = 0;
    resp_mode = 1; ack_delay = 0;
    miss_addr = 32'h0000_1234; fill_start = 1'b1;
    cyc();
    fill_start = 1'b0;
    for (int n = 1; n <= 60 && !got; n++) begin
      if (mem_req && w == 3 && !inj) begin
        fill_start = 1'b1; miss_addr = 32'h0000_8000; inj = 1;
      end else begin
        fill_start = 1'b0;
      end
      if (mem_req) begin
        vecs++;
        if (mem_addr !== base + 32'(4*w)) begin
          errs++; $display("FAIL restart_addr: got %h required %h", mem_addr, base + 32'(4*w));
        end
      end
      if (cache_we) w++;
      if (fill_done) begin
        got = 1;
        vecs++;
        if (n != 17 || tag_wdata !== 23'h9 || w != 8) begin
          errs++; $display("FAIL restart_done: cycle=%0d tag=%h words=%0d required 17 00009 8", n, tag_wdata, w);
        end
      end else cyc();
    end
    vecs++;
    if (!got) begin errs++; $display("FAIL restart_timeout: fill_done=0 required 1 within 60 cycles"); end
    fill_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (fill_done || busy) extra++;
    end
    vecs++;
    if (extra != 0) begin
      errs++; $display("FAIL restart_single_done: %0d busy/done cycles after fill, required 0", extra);
    end
  endtask

  task automatic test_reset_mid_fill();
    int w, tagc;
    bit hit, got;
    w = 0; hit = 0; got = 0; tagc = 0;
    resp_mode = 1; ack_delay = 0;
    miss_addr = 32'h0000_1234; fill_start = 1'b1;
    cyc();
    fill_start = 1'b0;
    for (int n = 1; n <= 40 && !hit; n++) begin
      if (mem_req && w == 4) hit = 1;
      else begin
        if (cache_we) w++;
        cyc();
      end
    end
    vecs++;
    if (!hit) begin errs++; $display("FAIL midreset_reach_word4: not reached, required within 40 cycles"); end
    RST_N = 1'b0;
    #1;
    vecs++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0 || cache_we !== 1'b0 ||
        tag_we !== 1'b0 || fill_done !== 1'b0) begin
      errs++; $display("FAIL midreset_outputs: busy=%b req=%b addr=%h we=%b tag_we=%b done=%b required all 0",
                       busy, mem_req, mem_addr, cache_we, tag_we, fill_done);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (tag_we || fill_done) tagc++;
    end
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (tag_we || fill_done || busy) tagc++;
    end
    vecs++;
    if (tagc != 0) begin errs++; $display("FAIL midreset_no_tag: %0d tag/done/busy cycles, required 0", tagc); end
    w = 0;
    miss_addr = 32'h0000_1234; fill_start = 1'b1;
    cyc();
    fill_start = 1'b0;
    vecs++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1220) begin
      errs++; $display("FAIL midreset_restart_word0: req=%b addr=%h required 1 00001220", mem_req, mem_addr);
    end
    for (int n = 1; n <= 60 && !got; n++) begin
      if (cache_we) begin
        vecs++;
        if (cache_word !== 3'(w)) begin
          errs++; $display("FAIL midreset_word_order: got %0d required %0d", cache_word, w);
        end
        w++;
      end
      if (fill_done) begin
        got = 1;
        vecs++;
        if (n != 17 || w != 8) begin
          errs++; $display("FAIL midreset_refill_done: cycle=%0d words=%0d required 17 8", n, w);
        end
      end else cyc();
    end
    vecs++;
    if (!got) begin errs++; $display("FAIL midreset_timeout: fill_done=0 required 1 within 60 cycles"); end
    cyc();
  endtask

  task automatic test_back_to_back();
    bit got;
    got = 0;
    resp_mode = 1; ack_delay = 0;
    miss_addr = 32'h0000_1234; fill_start = 1'b1;
    cyc();
    for (int n = 1; n <= 60 && !got; n++) begin
      if (fill_done) begin
        got = 1;
        vecs++;
        if (n != 17) begin errs++; $display("FAIL b2b_first_done: cycle=%0d required 17", n); end
      end else cyc();
    end
    vecs++;
    if (!got) begin errs++; $display("FAIL b2b_timeout1: fill_done=0 required 1 within 60 cycles"); end
    miss_addr = 32'h0000_2000;
    cyc();
    vecs++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errs++; $display("FAIL b2b_start_on_done_ignored: busy=%b req=%b required 0 0", busy, mem_req);
    end
    cyc();
    fill_start = 1'b0;
    vecs++;
    if (busy !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h0000_2000) begin
      errs++; $display("FAIL b2b_second_start: busy=%b req=%b addr=%h required 1 1 00002000", busy, mem_req, mem_addr);
    end
    got = 0;
    for (int n = 1; n <= 60 && !got; n++) begin
      if (fill_done) begin
        got = 1;
        vecs++;
        if (n != 17 || tag_wdata !== 23'h10 || cache_index !== 4'h0) begin
          errs++; $display("FAIL b2b_second_done: cycle=%0d tag=%h idx=%h required 17 00010 0", n, tag_wdata, cache_index);
        end
      end else cyc();
    end
    vecs++;
    if (!got) begin errs++; $display("FAIL b2b_timeout2: fill_done=0 required 1 within 60 cycles"); end
    cyc();
  endtask

  task automatic test_stray_ack();
    int w;
    bit got;
    w = 0; got = 0;
    resp_mode = 2;
    for (int i = 0; i < 4; i++) begin
      cyc();
      vecs++;
      if (busy !== 1'b0 || cache_we !== 1'b0 || mem_req !== 1'b0) begin
        errs++; $display("FAIL stray_idle: busy=%b we=%b req=%b required 0 0 0", busy, cache_we, mem_req);
      end
    end
    miss_addr = 32'h0000_1234; fill_start = 1'b1;
    cyc();
    fill_start = 1'b0;
    for (int n = 1; n <= 60 && !got; n++) begin
      if (cache_we) begin
        vecs++;
        if (cache_wdata !== 32'hDEAD_BEEF || cache_word !== 3'(w)) begin
          errs++; $display("FAIL stray_write: word=%0d data=%h required %0d deadbeef", cache_word, cache_wdata, w);
        end
        w++;
      end
      if (fill_done) begin
        got = 1;
        vecs++;
        if (n != 17 || w != 8) begin
          errs++; $display("FAIL stray_done: cycle=%0d words=%0d required 17 8", n, w);
        end
      end else cyc();
    end
    vecs++;
    if (!got) begin errs++; $display("FAIL stray_timeout: fill_done=0 required 1 within 60 cycles"); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      vecs++;
      if (busy !== 1'b0 || cache_we !== 1'b0 || fill_done !== 1'b0) begin
        errs++; $display("FAIL stray_after_done: busy=%b we=%b done=%b required 0 0 0", busy, cache_we, fill_done);
      end
    end
    resp_mode = 0;
    cyc();
  endtask

  initial begin
    vecs = 0; errs = 0;
    test_reset();
    test_basic();
    test_slow_memory();
    test_restart_ignored();
    test_reset_mid_fill();
    test_back_to_back();
    test_stray_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
